// File: rtl/gray_updown.sv
// gray_updown: modulo-MOD up/down counter with registered binary and Gray outputs.
// Ports: clk, rst (sync, active-high), en, dir (1=up), load, load_val (binary or Gray),
//        bin_out, gray_out (registered), tc (combinational terminal count),
//        wrap (pulse after a wrapping step), bad_load (pulse after a rejected load).
module gray_updown #(
   parameter int MOD       = 16,
   parameter int SATURATE  = 0,
   parameter int LOAD_GRAY = 0,
   localparam int W        = (MOD > 2) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] bin_out,
   output logic [W-1:0] gray_out,
   output logic         tc,
   output logic         wrap,
   output logic         bad_load
);

   localparam logic [W-1:0] MAX  = W'(MOD - 1);
   localparam logic [W:0]   MODV = (W+1)'(MOD);

   logic [W-1:0] bin_q, bin_d;
   logic [W-1:0] gray_q, gray_d;
   logic         wrap_q, wrap_d;
   logic         bad_q, bad_d;
   logic [W-1:0] dec;
   logic         load_ok;

   // Gray loads are converted with a prefix XOR from the MSB down.
   always_comb begin
      dec = load_val;
      if (LOAD_GRAY != 0) begin
         for (int i = W - 2; i >= 0; i--) begin
            dec[i] = dec[i+1] ^ load_val[i];
         end
      end
   end

   assign load_ok = ({1'b0, dec} < MODV);

   // Ends of range are found by comparison, so non-power-of-two MOD wraps cleanly.
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      bad_d  = 1'b0;
      if (load) begin
         if (load_ok) begin
            bin_d = dec;
         end else begin
            bad_d = 1'b1;
         end
      end else if (en) begin
         if (dir) begin
            if (bin_q == MAX) begin
               if (SATURATE == 0) begin
                  bin_d  = '0;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q + W'(1);
            end
         end else begin
            if (bin_q == '0) begin
               if (SATURATE == 0) begin
                  bin_d  = MAX;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q - W'(1);
            end
         end
      end
   end

   // Gray comes from the next binary value so both registers move together.
   assign gray_d = bin_d ^ (bin_d >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
         bad_q  <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
         bad_q  <= bad_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign wrap     = wrap_q;
   assign bad_load = bad_q;
   assign tc       = (dir && (bin_q == MAX)) || (!dir && (bin_q == '0));

endmodule
